// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer.
//   - FSM state encoding (ST_GAP exists only when TONE_SEQ_GAP_EN is defined)
//   - Pattern-step geometry: STEP_W / ADDR_W / MASK_W / DUR_W
//   - Field positions inside a 12-bit step word: [11:8] duration, [7:0] mask
//   - Helper functions that extract those fields
// Optional feature macro: TONE_SEQ_GAP_EN
package tone_pkg;

    localparam int STEP_W   = 12;
    localparam int ADDR_W   = 4;
    localparam int MASK_W   = 8;
    localparam int DUR_W    = 4;

    localparam int DUR_MSB  = 11;
    localparam int DUR_LSB  = 8;
    localparam int MASK_MSB = 7;
    localparam int MASK_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef TONE_SEQ_GAP_EN
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
`else
        ST_PLAY = 2'd1
`endif
    } state_e;

    function automatic logic [DUR_W-1:0] step_dur(input logic [STEP_W-1:0] step);
        return step[DUR_MSB:DUR_LSB];
    endfunction

    function automatic logic [MASK_W-1:0] step_mask(input logic [STEP_W-1:0] step);
        return step[MASK_MSB:MASK_LSB];
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control/status bundle of the tone sequencer.
//   wr_en/wr_addr/wr_data : pattern RAM write port
//   start/stop            : single-cycle play / abort requests
//   loop                  : level, sampled at the end of each pass
//   note_mask             : registered note-select to the tone modulator
//   step_idx/busy/done    : playback status
// Modports: master = controller driving the sequencer, slave = the sequencer.
interface tone_sequencer_if;
    import tone_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [STEP_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic              loop;
    logic [MASK_W-1:0] note_mask;
    logic [ADDR_W-1:0] step_idx;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop,
        input  note_mask, step_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop,
        output note_mask, step_idx, busy, done
    );

endinterface

// File: rtl/tone_sequencer_beat_timer.sv
// beat_timer: loadable countdown lasting dur*BEAT_DIV clock cycles.
//   clk, rst   : clock, synchronous active-high reset (clears both counters)
//   load       : restart the countdown for a step of length dur beats
//   run        : advance the countdown while high
//   dur        : step duration in beats (must be nonzero when loaded)
//   last       : high on the final cycle of the step
//   gap_next   : (TONE_SEQ_GAP_EN only) high one cycle before the trailing
//                GAP_CYCLES-long gap begins
// Optional feature macro: TONE_SEQ_GAP_EN
module beat_timer
    import tone_pkg::*;
#(
    parameter int unsigned BEAT_DIV   = 12500000,
    parameter int unsigned BEAT_W     = 24
`ifdef TONE_SEQ_GAP_EN
    ,parameter int unsigned GAP_CYCLES = 1000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DUR_W-1:0] dur,
    output logic             last
`ifdef TONE_SEQ_GAP_EN
    ,output logic            gap_next
`endif
);

    localparam logic [BEAT_W-1:0] BEAT_RELOAD = BEAT_W'(BEAT_DIV - 1);

    // beat_cnt counts cycles within a beat; beats_left counts whole beats
    // still to go after the current one.
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [DUR_W-1:0]  beats_left_q, beats_left_d;

    assign last = (beat_cnt_q == '0) && (beats_left_q == '0);

`ifdef TONE_SEQ_GAP_EN
    // GAP_CYCLES < BEAT_DIV, so the gap always falls inside the final beat.
    // Flagging it when GAP_CYCLES+1 cycles remain lets the registered
    // note_mask go silent for exactly the last GAP_CYCLES cycles.
    assign gap_next = (beats_left_q == '0) && (beat_cnt_q == BEAT_W'(GAP_CYCLES));
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        beat_cnt_d   = beat_cnt_q;
        beats_left_d = beats_left_q;
        if (load) begin
            beat_cnt_d   = BEAT_RELOAD;
            beats_left_d = dur - DUR_W'(1);
        end else if (run && !last) begin
            if (beat_cnt_q == '0) begin
                beat_cnt_d   = BEAT_RELOAD;
                beats_left_d = beats_left_q - DUR_W'(1);
            end else begin
                beat_cnt_d   = beat_cnt_q - BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            beat_cnt_q   <= '0;
            beats_left_q <= '0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: 16-step melody sequencer feeding the tone modulator's
// note-select input.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : tone_sequencer_if.slave (pattern write port, start/stop/loop,
//              note_mask / step_idx / busy / done)
// Each step is {duration[3:0], mask[7:0]}; duration 0 marks the end of the
// pattern. Steps play back-to-back, each for duration*BEAT_DIV cycles.
// Optional feature macro: TONE_SEQ_GAP_EN -- silences the last GAP_CYCLES
// cycles of every step (GAP state) without changing the step length.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned BEAT_DIV   = 12500000,
    parameter int unsigned BEAT_W     = 24
`ifdef TONE_SEQ_GAP_EN
    ,parameter int unsigned GAP_CYCLES = 1000000
`endif
) (
    input logic             clk,
    input logic             rst,
    tone_sequencer_if.slave bus
);

    // Pattern RAM: synchronous write, combinational read.
    logic [STEP_W-1:0] ram_q [2**ADDR_W];

    // NOTE: the pattern RAM has no reset; its contents survive rst by design.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            ram_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    state_e            state_q, state_d;
    logic [MASK_W-1:0] note_mask_q, note_mask_d;
    logic [ADDR_W-1:0] step_idx_q, step_idx_d;
    logic              done_q, done_d;

    logic              enter;
    logic [ADDR_W-1:0] enter_idx;
    logic [ADDR_W-1:0] next_idx;
    logic              timer_load;
    logic [DUR_W-1:0]  timer_dur;
    logic              timer_last;
`ifdef TONE_SEQ_GAP_EN
    logic              timer_gap_next;
`endif

    beat_timer #(
        .BEAT_DIV   (BEAT_DIV),
        .BEAT_W     (BEAT_W)
`ifdef TONE_SEQ_GAP_EN
        ,.GAP_CYCLES(GAP_CYCLES)
`endif
    ) u_beat_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .run     (state_q != ST_IDLE),
        .dur     (timer_dur),
        .last    (timer_last)
`ifdef TONE_SEQ_GAP_EN
        ,.gap_next(timer_gap_next)
`endif
    );

    assign next_idx = step_idx_q + ADDR_W'(1);  // wraps 15 -> 0

    always_comb begin
        state_d     = state_q;
        note_mask_d = note_mask_q;
        step_idx_d  = step_idx_q;
        done_d      = 1'b0;
        enter       = 1'b0;
        enter_idx   = '0;
        timer_load  = 1'b0;
        timer_dur   = '0;

        case (state_q)
            ST_IDLE: begin
                // stop wins over a simultaneous start
                if (bus.start && !bus.stop) begin
                    if (step_dur(ram_q[0]) != '0) begin
                        enter = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            default: begin  // ST_PLAY, and ST_GAP when enabled
                if (bus.stop) begin
                    state_d     = ST_IDLE;
                    note_mask_d = '0;
                    step_idx_d  = '0;
                end else if (timer_last) begin
                    if (step_dur(ram_q[next_idx]) != '0 && next_idx != '0) begin
                        enter     = 1'b1;
                        enter_idx = next_idx;
                    end else if (bus.loop && step_dur(ram_q[0]) != '0) begin
                        enter     = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        note_mask_d = '0;
                        step_idx_d  = '0;
                        done_d      = 1'b1;
                    end
                end
`ifdef TONE_SEQ_GAP_EN
                else if (state_q == ST_PLAY && timer_gap_next) begin
                    state_d     = ST_GAP;
                    note_mask_d = '0;
                end
`endif
            end
        endcase

        // Step entry latches the mask and duration, so a later write to the
        // sounding step only takes effect on its next visit.
        if (enter) begin
            state_d     = ST_PLAY;
            step_idx_d  = enter_idx;
            note_mask_d = step_mask(ram_q[enter_idx]);
            timer_load  = 1'b1;
            timer_dur   = step_dur(ram_q[enter_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            note_mask_q <= '0;
            step_idx_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_mask_q <= note_mask_d;
            step_idx_q  <= step_idx_d;
            done_q      <= done_d;
        end
    end

    assign bus.note_mask = note_mask_q;
    assign bus.step_idx  = step_idx_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer with BEAT_DIV=4 (GAP_CYCLES=1 when
// TONE_SEQ_GAP_EN is defined). Expected per-cycle outputs are pushed to a
// scoreboard queue from a bench-side copy of the pattern and popped one per
// clock while the DUT plays.
module tb_tone_sequencer;
    import tone_pkg::*;

    localparam int BD = 4;
`ifdef TONE_SEQ_GAP_EN
    localparam int GAP    = 1;
    localparam bit GAP_EN = 1'b1;
`else
    localparam int GAP    = 0;
    localparam bit GAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] mask;
        logic [3:0] idx;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic chk_idx;  // step_idx is only meaningful while playing or after rst
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tone_sequencer_if bus ();

    tone_sequencer #(
        .BEAT_DIV   (BD),
        .BEAT_W     (8)
`ifdef TONE_SEQ_GAP_EN
        ,.GAP_CYCLES(GAP)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    exp_t        sb[$];
    logic [11:0] mdl [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d, required 0", sb.size());
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t observe(input logic chk_idx);
        obs_t o;
        o.mask = bus.note_mask;
        o.idx  = chk_idx ? bus.step_idx : 4'h0;
        o.busy = bus.busy;
        o.done = bus.done;
        return o;
    endfunction

    task automatic push_cycle(input logic [7:0] mask, input int idx, input logic busy,
                              input logic done, input logic chk_idx);
        exp_t e;
        e.o.mask  = mask;
        e.o.idx   = 4'(idx);
        e.o.busy  = busy;
        e.o.done  = done;
        e.chk_idx = chk_idx;
        sb.push_back(e);
    endtask

    // Walk the bench pattern copy and push one expected entry per clock.
    task automatic push_pass(input int passes, input bit with_done);
        for (int p = 0; p < passes; p++) begin
            int i;
            i = 0;
            do begin
                int len;
                len = int'(mdl[i][11:8]) * BD;
                for (int c = 0; c < len; c++) begin
                    bit in_gap;
                    in_gap = GAP_EN && (c >= len - GAP);
                    push_cycle(in_gap ? 8'h00 : mdl[i][7:0], i, 1'b1, 1'b0, 1'b1);
                end
                i = (i + 1) % 16;
            end while (i != 0 && mdl[i][11:8] != 4'd0);
        end
        if (with_done) begin
            push_cycle(8'h00, 0, 1'b0, 1'b1, 1'b0);
            push_cycle(8'h00, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic write_step(input int addr, input int dur, input int mask);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = {4'(dur), 8'(mask)};
        mdl[addr]   = {4'(dur), 8'(mask)};
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_basic();
        write_step(0, 2, 8'h01);
        write_step(1, 1, 8'h80);
        write_step(2, 0, 8'h00);
    endtask

    // Returns at the negedge where the first cycle after start is visible.
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        o = observe(1'b1);
        tests_run++;
        if (o !== obs_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_hold: got %h, expected %h", o, obs_t'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        o = observe(1'b1);
        tests_run++;
        if (o !== obs_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_release: got %h, expected %h", o, obs_t'(0));
        end
    endtask

    task automatic test_single_pass();
        exp_t e;
        obs_t o;
        int   k = 0;
        write_basic();
        push_pass(1, 1'b1);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.chk_idx);
            tests_run++;
            if (o !== e.o) begin
                tests_failed++;
                $display("FAIL single_pass cycle %0d: got mask=%h idx=%h busy=%b done=%b, expected mask=%h idx=%h busy=%b done=%b",
                         k, o.mask, o.idx, o.busy, o.done, e.o.mask, e.o.idx, e.o.busy, e.o.done);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_loop();
        exp_t e;
        obs_t o;
        int   k = 0;
        bus.loop = 1'b1;
        push_pass(3, 1'b1);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.chk_idx);
            tests_run++;
            if (o !== e.o) begin
                tests_failed++;
                $display("FAIL loop cycle %0d: got mask=%h idx=%h busy=%b done=%b, expected mask=%h idx=%h busy=%b done=%b",
                         k, o.mask, o.idx, o.busy, o.done, e.o.mask, e.o.idx, e.o.busy, e.o.done);
            end
            if (k == 2 * 3 * BD + 2) bus.loop = 1'b0;  // drop loop inside the third pass
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_stop();
        exp_t e;
        obs_t o;
        int   k = 0;
        for (int c = 0; c < 3; c++) push_cycle(8'h01, 0, 1'b1, 1'b0, 1'b1);
        push_cycle(8'h00, 0, 1'b0, 1'b0, 1'b0);  // after stop: silent, no done
        push_cycle(8'h00, 0, 1'b0, 1'b0, 1'b0);  // stop+start together in IDLE
        push_pass(1, 1'b1);                      // replay, with start while busy ignored
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.chk_idx);
            tests_run++;
            if (o !== e.o) begin
                tests_failed++;
                $display("FAIL stop cycle %0d: got mask=%h idx=%h busy=%b done=%b, expected mask=%h idx=%h busy=%b done=%b",
                         k, o.mask, o.idx, o.busy, o.done, e.o.mask, e.o.idx, e.o.busy, e.o.done);
            end
            case (k)
                2: bus.stop = 1'b1;
                3: begin bus.stop = 1'b1; bus.start = 1'b1; end
                4: begin bus.stop = 1'b0; bus.start = 1'b1; end
                5: bus.start = 1'b0;
                6: bus.start = 1'b1;
                7: bus.start = 1'b0;
                default: ;
            endcase
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_duration();
        exp_t e;
        obs_t o;
        int   k = 0;
        write_step(0, 0, 8'h3C);
        push_cycle(8'h00, 0, 1'b0, 1'b1, 1'b0);
        push_cycle(8'h00, 0, 1'b0, 1'b0, 1'b0);
        push_cycle(8'h00, 0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.chk_idx);
            tests_run++;
            if (o !== e.o) begin
                tests_failed++;
                $display("FAIL zero_duration cycle %0d: got mask=%h idx=%h busy=%b done=%b, expected mask=%h idx=%h busy=%b done=%b",
                         k, o.mask, o.idx, o.busy, o.done, e.o.mask, e.o.idx, e.o.busy, e.o.done);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid_play();
        exp_t e;
        obs_t o;
        int   k = 0;
        write_basic();
        for (int c = 0; c < 3; c++) push_cycle(8'h01, 0, 1'b1, 1'b0, 1'b1);
        push_cycle(8'h00, 0, 1'b0, 1'b0, 1'b1);  // everything back to reset values
        push_pass(1, 1'b1);                      // pattern RAM survived rst
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.chk_idx);
            tests_run++;
            if (o !== e.o) begin
                tests_failed++;
                $display("FAIL rst_mid_play cycle %0d: got mask=%h idx=%h busy=%b done=%b, expected mask=%h idx=%h busy=%b done=%b",
                         k, o.mask, o.idx, o.busy, o.done, e.o.mask, e.o.idx, e.o.busy, e.o.done);
            end
            case (k)
                2: rst = 1'b1;
                3: begin rst = 1'b0; bus.start = 1'b1; end
                4: bus.start = 1'b0;
                default: ;
            endcase
            k++;
            @(negedge clk);
        end
    endtask

`ifdef TONE_SEQ_GAP_EN
    task automatic test_gap();
        exp_t e;
        obs_t o;
        int   k = 0;
        write_step(0, 2, 8'h04);
        write_step(1, 0, 8'h00);
        for (int c = 0; c < 7; c++) push_cycle(8'h04, 0, 1'b1, 1'b0, 1'b1);
        push_cycle(8'h00, 0, 1'b1, 1'b0, 1'b1);
        push_cycle(8'h00, 0, 1'b0, 1'b1, 1'b0);
        push_cycle(8'h00, 0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.chk_idx);
            tests_run++;
            if (o !== e.o) begin
                tests_failed++;
                $display("FAIL gap cycle %0d: got mask=%h idx=%h busy=%b done=%b, expected mask=%h idx=%h busy=%b done=%b",
                         k, o.mask, o.idx, o.busy, o.done, e.o.mask, e.o.idx, e.o.busy, e.o.done);
            end
            k++;
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_all_steps();
        exp_t       e;
        obs_t       o;
        int         k = 0;
        logic [3:0] n;
        for (int i = 0; i < 16; i++) begin
            n = 4'(i);
            write_step(i, 1, {n, ~n});
        end
        mdl[5] = {4'd1, 8'hA5};  // rewritten while step 2 sounds
        push_pass(1, 1'b1);
        pulse_start();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.chk_idx);
            tests_run++;
            if (o !== e.o) begin
                tests_failed++;
                $display("FAIL all_steps cycle %0d: got mask=%h idx=%h busy=%b done=%b, expected mask=%h idx=%h busy=%b done=%b",
                         k, o.mask, o.idx, o.busy, o.done, e.o.mask, e.o.idx, e.o.busy, e.o.done);
            end
            if (k == 2 * BD + 1) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 4'd5;
                bus.wr_data = {4'd1, 8'hA5};
            end
            if (k == 2 * BD + 2) bus.wr_en = 1'b0;
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop    = 1'b0;

        test_reset();
        test_single_pass();
        test_loop();
        test_stop();
        test_zero_duration();
        test_rst_mid_play();
`ifdef TONE_SEQ_GAP_EN
        test_gap();
`endif
        test_all_steps();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Programmable melody sequencer that drives the 8-bit note-select input (`data_in`) of the tone modulator. Each bit of `note_mask` enables one of the eight divided-clock tones.
- Holds a 16-step pattern RAM. Each step is an 8-bit note mask plus a 4-bit duration in beats.
- Plays the steps in order at a fixed beat rate, with optional looping.
- Sits directly upstream of the modulator, on the same clock.

Parameters:
- BEAT_DIV, 12500000, clk cycles per beat (0.25 s at 50 MHz); must be >= 1.
- BEAT_W, 24, width of the beat counter; 2^BEAT_W must exceed BEAT_DIV.
- GAP_CYCLES, 1000000, silent gap length in clk cycles; used only with TONE_SEQ_GAP_EN; must be >= 1 and < BEAT_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  pattern RAM write strobe
- wr_addr  in  4  step index to write
- wr_data  in  12  [11:8] duration in beats (0 = end marker), [7:0] note mask
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- loop  in  1  level; sampled at the end of each pass
- note_mask  out  8  to modulator `data_in`; registered
- step_idx  out  4  index of the step currently sounding
- busy  out  1  high while playing
- done  out  1  one-cycle pulse when a non-looping pass completes

Behaviour:
- Reset values: note_mask=0, step_idx=0, busy=0, done=0, state=IDLE, counters=0.
- Pattern RAM is not reset; its contents survive rst.
- RAM writes take effect on the clock edge.
- RAM reads are combinational, so a step rewritten before it is reached is played with the new value.
- A write during play to the currently sounding step does not change the current note. The new value is used on its next visit.
- States are IDLE, PLAY and GAP (GAP exists only with the macro).

IDLE:
- On start, read entry 0.
- If its duration is nonzero: the next cycle is PLAY with note_mask=entry0.mask, step_idx=0, busy=1.
- If its duration is 0: the next cycle gives done=1 and the block stays in IDLE with note_mask=0.

PLAY:
- Each step holds note_mask for exactly duration*BEAT_DIV cycles.
- The beat counter and beat countdown are loaded when the step is entered.
- On the last cycle of a step, evaluate the next index n = step_idx+1, wrapping 15 -> 0:
  - If entry n has a nonzero duration and n != 0, advance to n with no idle cycle between notes.
  - If entry n is an end marker, or the index wrapped, and loop=1: restart at entry 0, provided entry 0's duration is nonzero.
  - Otherwise end the pass: the next cycle gives note_mask=0, busy=0, done=1, state=IDLE.

stop and start:
- stop in any non-IDLE state: the next cycle gives note_mask=0, busy=0, state=IDLE, and no done pulse.
- stop in IDLE has no effect.
- If stop and start are asserted together, stop wins.
- start while busy is ignored.
- rst mid-play behaves like stop, except that done and all counters also clear.

Optional Feature:
- Macro: TONE_SEQ_GAP_EN.
- Defined: the last GAP_CYCLES cycles of each step's duration are spent in GAP with note_mask=0, giving an articulation gap. The total step length is unchanged.
- Defined: stop and end-of-pass handling still apply during GAP.
- Undefined: the GAP state and its counter are absent, and notes are contiguous.

Decomposition:
- Shared package `tone_pkg` holds:
  - state enum
  - STEP_W=12, ADDR_W=4, MASK_W=8, DUR_W=4
  - field-slice localparams for wr_data
- One sub-module, `beat_timer`: loadable countdown of duration*BEAT_DIV cycles, with a `last` flag output.
- The FSM and RAM stay in `tone_sequencer`.

Test Plan:
- BEAT_DIV=4. Write entry0={2,0x01}, entry1={1,0x80}, entry2={0,x}. Pulse start -> 0x01 for 8 cycles, then 0x80 for 4 cycles, then note_mask=0, done=1 for exactly 1 cycle, busy=0.
- Same pattern with loop=1 -> sequence 0x01,0x80 repeats. Drop loop mid-pass -> the pass completes and done pulses once.
- stop asserted 3 cycles into entry0 -> the next cycle gives note_mask=0, busy=0, no done. A subsequent start replays from entry 0.
- entry0 duration 0, start -> done pulses on the next cycle, note_mask stays 0, busy never rises.
- All 16 entries with duration 1 and loop=0 -> step_idx runs 0..15 and the pass ends after 16*BEAT_DIV cycles. Rewrite entry5 during step 2 -> the new mask is heard at step 5.
- With TONE_SEQ_GAP_EN, GAP_CYCLES=1, entry0={2,0x04} -> 7 cycles of 0x04 then 1 cycle of 0. Also check that rst during play forces all outputs to 0 on the next cycle.
